// File: rtl/serial_port_pkg.sv
// Shared types and address defaults for the byte-serial word port.
package serial_port_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD_ANN,
    S_LOAD,
    S_STORE,
    S_DONE
  } port_state_e;

  localparam logic [7:0] STALL_ADDR_DEF = 8'hFF;
  localparam logic [7:0] LOAD_BASE_DEF  = 8'h01;
  localparam logic [7:0] STORE_BASE_DEF = 8'h10;

  function automatic int unsigned beats(input int unsigned word_w, input int unsigned bus_w);
    return word_w / bus_w;
  endfunction

endpackage

// File: rtl/serial_word_port_beat_shifter.sv
// Beat counter plus word assembly (indexed capture) / disassembly (right shift) register.
module beat_shifter
  import serial_port_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BUS_W  = 8,
  localparam int unsigned BEATS = beats(WORD_W, BUS_W),
  localparam int unsigned CNT_W = $clog2(BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic [BUS_W-1:0]  data_in,
  input  logic              shift_in,
  input  logic              shift_out,
  output logic [WORD_W-1:0] word,
  output logic [CNT_W-1:0]  beat,
  output logic              last_beat
);

  assign last_beat = (beat == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      beat <= '0;
    end else if (load) begin
      word <= load_word;
      beat <= '0;
    end else if (shift_in) begin
      // the counter may step one past the data beats (checksum beat); no slot is written then
      for (int unsigned i = 0; i < BEATS; i++) begin
        if (beat == CNT_W'(i)) word[i*BUS_W +: BUS_W] <= data_in;
      end
      beat <= beat + CNT_W'(1);
    end else if (shift_out) begin
      word <= word >> BUS_W;
      beat <= beat + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_word_port.sv
// Byte-serial word transfer engine: fetch/load assembly, store serialisation, stall announce.
// Optional checksum beat on every transfer when SERIAL_WORD_PORT_CKSUM_EN is defined.
module serial_word_port
  import serial_port_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BUS_W  = 8,
  parameter int unsigned ADDR_W = 8,
  parameter logic [ADDR_W-1:0] STALL_ADDR = ADDR_W'(STALL_ADDR_DEF),
  parameter logic [ADDR_W-1:0] LOAD_BASE  = ADDR_W'(LOAD_BASE_DEF),
  parameter logic [ADDR_W-1:0] STORE_BASE = ADDR_W'(STORE_BASE_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BUS_W-1:0]  data_in,
  output logic [BUS_W-1:0]  data_out,
  output logic [ADDR_W-1:0] address_out,
  input  logic              fetch_req,
  input  logic              load_req,
  input  logic              store_req,
  input  logic [WORD_W-1:0] store_data,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              is_instr,
  output logic              busy,
  output logic              err
);

  localparam int unsigned BEATS = beats(WORD_W, BUS_W);
  localparam int unsigned CNT_W = $clog2(BEATS + 1);

  if (BEATS < 2 || (WORD_W % BUS_W) != 0) begin : g_bad_cfg
    $error("serial_word_port: WORD_W must be a multiple of BUS_W giving at least 2 beats");
  end

  port_state_e state, state_d;
  logic [ADDR_W-1:0] addr_d, base;
  logic [BUS_W-1:0]  dout_d;
  logic [WORD_W-1:0] wout_d, sh_word;
  logic [CNT_W-1:0]  sh_beat;
  logic wv_d, ii_d, err_d, sh_load, sh_in, sh_out, sh_last;

`ifdef SERIAL_WORD_PORT_CKSUM_EN
  logic [BUS_W-1:0] cks_q, cks_d;

  function automatic logic [BUS_W-1:0] fold(input logic [WORD_W-1:0] w);
    logic [BUS_W-1:0] x;
    x = '0;
    for (int unsigned i = 0; i < BEATS; i++) x ^= w[i*BUS_W +: BUS_W];
    return x;
  endfunction
`endif

  beat_shifter #(.WORD_W(WORD_W), .BUS_W(BUS_W)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_word (store_data),
    .data_in   (data_in),
    .shift_in  (sh_in),
    .shift_out (sh_out),
    .word      (sh_word),
    .beat      (sh_beat),
    .last_beat (sh_last)
  );

  assign busy = (state != S_IDLE);
  assign base = (state == S_LOAD) ? LOAD_BASE : '0;

  // Outputs are registered from the next-state decision so they line up with the beat they describe.
  always_comb begin
    state_d = state;
    addr_d  = '0;
    dout_d  = '0;
    wout_d  = word_out;
    wv_d    = 1'b0;
    ii_d    = 1'b0;
    err_d   = 1'b0;
    sh_load = 1'b0;
    sh_in   = 1'b0;
    sh_out  = 1'b0;
`ifdef SERIAL_WORD_PORT_CKSUM_EN
    cks_d   = cks_q;
`endif
    case (state)
      S_IDLE: begin
        if (store_req) begin
          state_d = S_STORE;
          sh_load = 1'b1;
          addr_d  = STORE_BASE;
          dout_d  = store_data[BUS_W-1:0];
`ifdef SERIAL_WORD_PORT_CKSUM_EN
          cks_d   = fold(store_data);
`endif
        end else if (load_req) begin
          state_d = S_LOAD_ANN;
          sh_load = 1'b1;
          addr_d  = STALL_ADDR;
        end else if (fetch_req) begin
          state_d = S_FETCH;
          sh_load = 1'b1;
        end
      end
      S_LOAD_ANN: begin
        state_d = S_LOAD;
        addr_d  = LOAD_BASE;
      end
      S_FETCH, S_LOAD: begin
`ifdef SERIAL_WORD_PORT_CKSUM_EN
        if (sh_beat == CNT_W'(BEATS)) begin
          state_d = S_DONE;
          wv_d    = 1'b1;
          ii_d    = (state == S_FETCH);
          wout_d  = sh_word;
          err_d   = (data_in != fold(sh_word));
        end else begin
          sh_in  = 1'b1;
          addr_d = base + ADDR_W'(sh_beat) + ADDR_W'(1);
        end
`else
        sh_in = 1'b1;
        if (sh_last) begin
          state_d = S_DONE;
          wv_d    = 1'b1;
          ii_d    = (state == S_FETCH);
          // last beat is still on data_in; splice it in so word_out and word_valid move together
          wout_d  = sh_word;
          wout_d[WORD_W-BUS_W +: BUS_W] = data_in;
        end else begin
          addr_d = base + ADDR_W'(sh_beat) + ADDR_W'(1);
        end
`endif
      end
      S_STORE: begin
`ifdef SERIAL_WORD_PORT_CKSUM_EN
        if (sh_beat == CNT_W'(BEATS)) begin
          state_d = S_DONE;
          wv_d    = 1'b1;
        end else if (sh_last) begin
          sh_out = 1'b1;
          addr_d = STORE_BASE + ADDR_W'(BEATS);
          dout_d = cks_q;
        end else begin
          sh_out = 1'b1;
          addr_d = STORE_BASE + ADDR_W'(sh_beat) + ADDR_W'(1);
          dout_d = sh_word[BUS_W +: BUS_W];
        end
`else
        if (sh_last) begin
          state_d = S_DONE;
          wv_d    = 1'b1;
        end else begin
          sh_out = 1'b1;
          addr_d = STORE_BASE + ADDR_W'(sh_beat) + ADDR_W'(1);
          dout_d = sh_word[BUS_W +: BUS_W];
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      address_out <= '0;
      data_out    <= '0;
      word_out    <= '0;
      word_valid  <= 1'b0;
      is_instr    <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_d;
      address_out <= addr_d;
      data_out    <= dout_d;
      word_out    <= wout_d;
      word_valid  <= wv_d;
      is_instr    <= ii_d;
      err         <= err_d;
    end
  end

`ifdef SERIAL_WORD_PORT_CKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cks_q <= '0;
    else     cks_q <= cks_d;
  end
`endif

  a_load_not_stall: assert property (@(posedge clk) disable iff (rst)
    (state == S_LOAD) |-> (address_out != STALL_ADDR));

endmodule

// File: tb/tb_serial_word_port.sv
// Scoreboard bench for serial_word_port: host beat model plus word_valid monitor.
module tb_serial_word_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic [7:0]  address_out;
  logic        fetch_req = 1'b0, load_req = 1'b0, store_req = 1'b0;
  logic [31:0] store_data = '0;
  logic [31:0] word_out;
  logic        word_valid, is_instr, busy, err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] word;
    logic        instr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] last_word = '0;

  serial_word_port #(
    .WORD_W(32), .BUS_W(8), .ADDR_W(8),
    .STALL_ADDR(8'hFF), .LOAD_BASE(8'h01), .STORE_BASE(8'h10)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out),
    .address_out(address_out), .fetch_req(fetch_req), .load_req(load_req),
    .store_req(store_req), .store_data(store_data), .word_out(word_out),
    .word_valid(word_valid), .is_instr(is_instr), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  always @(negedge clk) begin
    if (!rst && word_valid === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: word_valid high with word_out=%h, none expected", word_out);
      end else begin
        mon_e = sb.pop_front();
        if (word_out !== mon_e.word || is_instr !== mon_e.instr || err !== mon_e.err) begin
          miscompares++;
          $display("FAIL word: got word_out=%h is_instr=%b err=%b, need %h %b %b",
                   word_out, is_instr, err, mon_e.word, mon_e.instr, mon_e.err);
        end
      end
    end
  end

  task automatic run_inbound(input bit fetch, input logic [31:0] w, input logic [7:0] ck,
                             output int waited);
    logic [7:0] base, start_addr;
    bit exp_err;
    base       = fetch ? 8'h00 : 8'h01;
    start_addr = fetch ? 8'h00 : 8'hFF;
    exp_err    = (xor_bytes(w) != ck);
`ifndef SERIAL_WORD_PORT_CKSUM_EN
    exp_err    = 1'b0;
`endif
    sb.push_back('{word: w, instr: fetch, err: exp_err});
    last_word = w;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(busy === 1'b1 && word_valid === 1'b0 && address_out === start_addr) && waited < 30);
    vectors++;
    if (!(busy === 1'b1 && address_out === start_addr)) begin
      miscompares++;
      $display("FAIL start_%s: address_out=%h busy=%b after %0d cycles, need %h",
               fetch ? "fetch" : "load", address_out, busy, waited, start_addr);
      fetch_req = 1'b0; load_req = 1'b0;
      return;
    end
    if (!fetch) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      vectors++;
      if (address_out !== 8'(base + k)) begin
        miscompares++;
        $display("FAIL beat_addr: beat %0d address_out=%h, need %h", k, address_out, 8'(base + k));
      end
      data_in = w[k*8 +: 8];
    end
`ifdef SERIAL_WORD_PORT_CKSUM_EN
    @(negedge clk);
    vectors++;
    if (address_out !== 8'(base + 4)) begin
      miscompares++;
      $display("FAIL cksum_addr: address_out=%h, need %h", address_out, 8'(base + 4));
    end
    data_in = ck;
`endif
    @(negedge clk);
    vectors++;
    if (word_valid !== 1'b1 || address_out !== 8'h00) begin
      miscompares++;
      $display("FAIL done: word_valid=%b address_out=%h, need 1 00", word_valid, address_out);
    end
    if (fetch) fetch_req = 1'b0;
    else       load_req  = 1'b0;
  endtask

  task automatic run_store(input logic [31:0] w, output int waited);
    sb.push_back('{word: last_word, instr: 1'b0, err: 1'b0});
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(busy === 1'b1 && word_valid === 1'b0 && address_out === 8'h10) && waited < 30);
    vectors++;
    if (address_out !== 8'h10) begin
      miscompares++;
      $display("FAIL start_store: address_out=%h after %0d cycles, need 10", address_out, waited);
      store_req = 1'b0;
      return;
    end
    store_data = ~w;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      vectors++;
      if (address_out !== 8'(8'h10 + k) || data_out !== w[k*8 +: 8]) begin
        miscompares++;
        $display("FAIL store_beat: beat %0d address_out=%h data_out=%h, need %h %h",
                 k, address_out, data_out, 8'(8'h10 + k), w[k*8 +: 8]);
      end
    end
`ifdef SERIAL_WORD_PORT_CKSUM_EN
    @(negedge clk);
    vectors++;
    if (address_out !== 8'h14 || data_out !== xor_bytes(w)) begin
      miscompares++;
      $display("FAIL store_cksum: address_out=%h data_out=%h, need 14 %h",
               address_out, data_out, xor_bytes(w));
    end
`endif
    @(negedge clk);
    vectors++;
    if (word_valid !== 1'b1 || address_out !== 8'h00) begin
      miscompares++;
      $display("FAIL store_done: word_valid=%b address_out=%h, need 1 00", word_valid, address_out);
    end
    store_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({address_out, data_out} !== 16'h0 || word_out !== 32'h0 ||
        {word_valid, is_instr, busy, err} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset: addr=%h dout=%h word=%h wv=%b ii=%b busy=%b err=%b, need all 0",
               address_out, data_out, word_out, word_valid, is_instr, busy, err);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b, need 0", busy);
    end
  endtask

  task automatic test_fetch;
    int waited;
    fetch_req = 1'b1;
    run_inbound(1'b1, 32'h8D080004, 8'h81, waited);
    vectors++;
    if (waited != 1) begin
      miscompares++;
      $display("FAIL fetch_accept: accepted after %0d cycles, need 1", waited);
    end
    @(negedge clk);
  endtask

  task automatic test_load;
    int waited;
    load_req = 1'b1;
    run_inbound(1'b0, 32'hDEADBEEF, xor_bytes(32'hDEADBEEF), waited);
    vectors++;
    if (waited != 1) begin
      miscompares++;
      $display("FAIL load_accept: stall announced after %0d cycles, need 1", waited);
    end
    @(negedge clk);
  endtask

  task automatic test_store;
    int waited;
    store_data = 32'h12345678;
    store_req  = 1'b1;
    run_store(32'h12345678, waited);
    vectors++;
    if (waited != 1) begin
      miscompares++;
      $display("FAIL store_accept: accepted after %0d cycles, need 1", waited);
    end
    @(negedge clk);
  endtask

  task automatic test_arbitration;
    int ws, wl, wf;
    store_data = 32'hCAFEF00D;
    store_req = 1'b1; load_req = 1'b1; fetch_req = 1'b1;
    run_store(32'hCAFEF00D, ws);
    run_inbound(1'b0, 32'h01020304, xor_bytes(32'h01020304), wl);
    run_inbound(1'b1, 32'h11223344, xor_bytes(32'h11223344), wf);
    vectors++;
    if (ws != 1 || wl != 2 || wf != 2) begin
      miscompares++;
      $display("FAIL arbitration: accept gaps store=%0d load=%0d fetch=%0d, need 1 2 2", ws, wl, wf);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int waited;
    fetch_req = 1'b1;
    @(negedge clk);
    data_in = 8'h11;
    @(negedge clk);
    data_in = 8'h22;
    @(negedge clk);
    vectors++;
    if (address_out !== 8'h02) begin
      miscompares++;
      $display("FAIL reset_mid_beat: address_out=%h, need 02", address_out);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({address_out, data_out} !== 16'h0 || word_out !== 32'h0 ||
        {word_valid, is_instr, busy, err} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_mid: addr=%h dout=%h word=%h wv=%b ii=%b busy=%b err=%b, need all 0",
               address_out, data_out, word_out, word_valid, is_instr, busy, err);
    end
    fetch_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_word = '0;
    @(negedge clk);
    fetch_req = 1'b1;
    run_inbound(1'b1, 32'hAABBCCDD, xor_bytes(32'hAABBCCDD), waited);
    @(negedge clk);
  endtask

`ifdef SERIAL_WORD_PORT_CKSUM_EN
  task automatic test_cksum;
    int waited;
    fetch_req = 1'b1;
    run_inbound(1'b1, 32'h8D080004, 8'h81, waited);
    @(negedge clk);
    fetch_req = 1'b1;
    run_inbound(1'b1, 32'h8D080004, 8'h80, waited);
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_arbitration();
    test_reset_mid();
`ifdef SERIAL_WORD_PORT_CKSUM_EN
    test_cksum();
`endif
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d words never delivered, need 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_word_port.md
Name: serial_word_port

Overview:
- Parametrised byte-serial word transfer engine between the core and the narrow external pin bus (data_in / data_out / address_out).
- Assembles instruction and load-data words from BUS_W-wide beats, LSB-first.
- Serialises store words back out onto the bus.
- Announces stalls to the host by driving STALL_ADDR on address_out.
- Successor to the fixed 8-bit/32-bit loader: width, beat count and address map are generic, and it adds an outbound store path plus request arbitration.

Parameters:
- WORD_W, 32: core word width; must be a multiple of BUS_W.
- BUS_W, 8: external data bus width.
- ADDR_W, 8: address_out width.
- STALL_ADDR, all-ones (8'hFF): address announcing a load stall.
- LOAD_BASE, 1: address_out value of the first load beat.
- STORE_BASE, 8'h10: address_out value of the first store beat.
- Derived localparam BEATS = WORD_W/BUS_W. Elaboration error if BEATS < 2 or WORD_W % BUS_W != 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- data_in  in  BUS_W  inbound beat, sampled on rising clk.
- data_out  out  BUS_W  outbound store beat.
- address_out  out  ADDR_W  beat index / stall marker to host.
- fetch_req  in  1  core requests the next instruction.
- load_req  in  1  core requests a data word (mem_read).
- store_req  in  1  core requests a store (mem_write).
- store_data  in  WORD_W  store word, captured when store is accepted.
- word_out  out  WORD_W  assembled word; holds until the next transfer completes.
- word_valid  out  1  one-cycle pulse when word_out is updated or a store completes.
- is_instr  out  1  qualifies word_valid: 1 = instruction, 0 = data or store.
- busy  out  1  high in every state except IDLE.
- err  out  1  checksum error pulse (see Optional Feature).

Behaviour:
- Reset values: state IDLE; address_out 0, data_out 0, word_out 0, word_valid 0, is_instr 0, busy 0, err 0; beat counter 0. Reset mid-transfer aborts the transfer immediately, with no partial word_valid.
- States: IDLE, FETCH, LOAD_ANN, LOAD, STORE, DONE.
- IDLE: requests are sampled only in IDLE, and only on the clock edge. Priority is store > load > fetch. Requests raised in any other state are ignored, so the core must hold its request until word_valid.
- Request acceptance:
  - store_req: capture store_data, go to STORE.
  - load_req: go to LOAD_ANN.
  - fetch_req: go to FETCH.
- FETCH: lasts BEATS cycles. In beat k, address_out = k and data_in is written into word bits [k*BUS_W +: BUS_W] on the clock edge. After beat BEATS-1, go to DONE with is_instr = 1.
- LOAD_ANN: one cycle; address_out = STALL_ADDR; no capture. Then go to LOAD.
- LOAD: as FETCH, but address_out = LOAD_BASE + k. Then go to DONE with is_instr = 0.
- STORE: lasts BEATS cycles. In beat k, data_out = store word bits [k*BUS_W +: BUS_W] and address_out = STORE_BASE + k. Then go to DONE with is_instr = 0; word_out is unchanged.
- DONE: one cycle. word_valid = 1 and word_out updates (inbound transfers only); address_out = 0. Then return to IDLE.
- Registered outputs: address_out, data_out, word_out, word_valid, is_instr and err change only on the clock edge.
- Latency, accepting edge to word_valid high:
  - fetch: BEATS + 1 cycles.
  - load: BEATS + 2 cycles.
  - store: BEATS + 1 cycles.
- Back-to-back: a request held through DONE is accepted on the IDLE cycle that follows, giving a minimum 1-cycle IDLE gap between transfers.
- Address arithmetic is modulo 2^ADDR_W. LOAD_BASE + k must not equal STALL_ADDR; this is an assertion in simulation.

Optional Feature:
- Macro: SERIAL_WORD_PORT_CKSUM_EN.
- Defined:
  - Inbound (FETCH/LOAD): one extra beat after the last data beat, with address_out = its base + BEATS. That beat carries the XOR of all data beats.
  - On mismatch, err pulses together with word_valid; word_out is still updated.
  - STORE appends one beat driving the XOR of the data beats.
  - All latencies grow by 1.
- Undefined: no extra beat; err is tied to 0.

Decomposition:
- Package serial_port_pkg holds:
  - state enum/localparams.
  - address constants STALL_ADDR_DEF, LOAD_BASE_DEF, STORE_BASE_DEF.
  - function beats(WORD_W, BUS_W).
- One sub-module, beat_shifter:
  - beat counter plus word assembly/disassembly register, parametrised on WORD_W and BUS_W.
  - Inputs: load, shift_in enable, shift_out enable.
  - Outputs: word, current beat, last_beat flag.
- The top-level holds only the FSM and output registers.

Test Plan:
- Fetch: fetch_req, data_in = 04, 00, 08, 8D → address_out 00..03; word_out = 0x8D080004, is_instr = 1, word_valid on the 5th cycle after acceptance.
- Load: load_req → address_out = FF for one cycle. Then data_in = EF, BE, AD, DE at address_out 01..04 → word_out = 0xDEADBEEF, is_instr = 0.
- Store: store_req with store_data = 0x12345678 → data_out 78, 56, 34, 12 at address_out 10..13, then word_valid; word_out unchanged.
- Arbitration: fetch_req, load_req and store_req all high in the same cycle → STORE first. With requests held, LOAD follows, then FETCH, each separated by one IDLE cycle.
- Reset mid-transfer: rst asserted during beat 2 of a fetch, asynchronously between edges → all outputs 0 immediately, no word_valid. After release, a new fetch of 0xAABBCCDD completes correctly.
- Checksum (with SERIAL_WORD_PORT_CKSUM_EN): fetch 04, 00, 08, 8D followed by checksum 81 → err = 0. The same beats with checksum 80 → err = 1 together with word_valid.
